// File: rtl/ttlc_dbg_pkg.sv
// Shared encodings for the TTLC debug run-control page: run states, halt reasons,
// register offsets and the default page select.
package ttlc_dbg_pkg;

    localparam int unsigned DBG_DW = 16;

    typedef enum logic [1:0] {
        ST_HALTED   = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2
    } run_state_t;

    typedef enum logic [1:0] {
        RSN_NONE = 2'd0,
        RSN_HOST = 2'd1,
        RSN_BRK  = 2'd2,
        RSN_STEP = 2'd3
    } halt_reason_t;

    localparam logic [3:0] OFS_CTRL     = 4'h0;
    localparam logic [3:0] OFS_PC       = 4'h1;
    localparam logic [3:0] OFS_STEP_N   = 4'h2;
    localparam logic [3:0] OFS_BRK_EN   = 4'h3;
    localparam logic [3:0] OFS_HIT      = 4'h4;
    localparam logic [3:0] OFS_ICOUNT   = 4'h5;
    localparam logic [3:0] OFS_BRK_ADDR = 4'h8;

    localparam logic [3:0] PAGE_DEFAULT = 4'h4;

endpackage

// File: rtl/ttlc_brk_match.sv
// Per-breakpoint PC comparators; match[i] is set when breakpoint i is enabled and hits.
module ttlc_brk_match
    import ttlc_dbg_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 12,
    parameter int unsigned NUM_BRK  = 4
) (
    input  logic [PC_WIDTH-1:0]               pc,
    input  logic [NUM_BRK-1:0][PC_WIDTH-1:0]  brk_addr,
    input  logic [NUM_BRK-1:0]                brk_en,
    output logic [NUM_BRK-1:0]                match
);

    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < NUM_BRK; i++) begin
            match[i] = brk_en[i] && (brk_addr[i] == pc);
        end
    end

endmodule

// File: rtl/ttlc_run_ctrl.sv
// Run-control and breakpoint unit for the TTLC core: run/step/halt FSM, maskable
// PC breakpoints, sticky hit/reason status and a retired-instruction counter.
module ttlc_run_ctrl
    import ttlc_dbg_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 12,
    parameter int unsigned NUM_BRK  = 4,
    parameter logic [3:0]  PAGE     = PAGE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          dbg_a,
    input  logic [15:0]         dbg_di,
    output logic [15:0]         dbg_do,
    input  logic                dbg_we,
    input  logic                dbg_rd,
    output logic                dbg_ready,
    input  logic [PC_WIDTH-1:0] ttlc_pc,
    input  logic                ttlc_i_ready,
    input  logic                ext_halt_req,
    input  logic                ttlc_data_in,
    input  logic                ttlc_data_out,
    input  logic                ttlc_result_reg,
    output logic                ttlc_halt,
    output logic                halt_event
);

    run_state_t                       state;
    halt_reason_t                     reason;
    logic                             skip;
    logic [DBG_DW-1:0]                count;
    logic [DBG_DW-1:0]                icount;
    logic [NUM_BRK-1:0]               brk_en;
    logic [NUM_BRK-1:0]               hit;
    logic [NUM_BRK-1:0]               match;
    logic [NUM_BRK-1:0]               hit_clr;
    logic [NUM_BRK-1:0][PC_WIDTH-1:0] brk_addr;

    logic              sel, wr, ctrl_wr, stepn_wr, step_cmd;
    logic              brk_live, brk_hit, step_done;
    logic [3:0]        ofs;
    logic [DBG_DW-1:0] step_load;

    assign ofs       = dbg_a[3:0];
    assign sel       = (dbg_a[7:4] == PAGE);
    assign wr        = sel && dbg_we;
    assign dbg_ready = sel && (dbg_rd || dbg_we);

    // Host commands that drive the FSM; these outrank every core-side event.
    assign ctrl_wr   = wr && (ofs == OFS_CTRL);
    assign stepn_wr  = wr && (ofs == OFS_STEP_N) && (dbg_di != '0);
    assign step_cmd  = (ctrl_wr && dbg_di[1]) || stepn_wr;
    assign step_load = stepn_wr ? dbg_di : DBG_DW'(1);

    assign brk_live  = (state == ST_RUNNING) && !skip;
    assign brk_hit   = brk_live && (|match);
    assign step_done = (state == ST_STEPPING) && ttlc_i_ready && (count == DBG_DW'(1));
    assign hit_clr   = (ctrl_wr && dbg_di[2])      ? '1 :
                       (wr && (ofs == OFS_HIT))    ? dbg_di[NUM_BRK-1:0] : '0;

    ttlc_brk_match #(
        .PC_WIDTH (PC_WIDTH),
        .NUM_BRK  (NUM_BRK)
    ) u_brk_match (
        .pc       (ttlc_pc),
        .brk_addr (brk_addr),
        .brk_en   (brk_en),
        .match    (match)
    );

    // Run-control FSM with halt reason, skip flag and step counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_HALTED;
            reason     <= RSN_NONE;
            skip       <= 1'b0;
            count      <= '0;
            ttlc_halt  <= 1'b1;
            halt_event <= 1'b0;
        end else begin
            halt_event <= 1'b0;
            if (state == ST_RUNNING && ttlc_i_ready) skip <= 1'b0;
            if (state == ST_STEPPING && ttlc_i_ready) count <= count - DBG_DW'(1);
            if (ctrl_wr && dbg_di[2]) reason <= RSN_NONE;

            if (step_cmd) begin
                state     <= ST_STEPPING;
                ttlc_halt <= 1'b0;
                count     <= step_load;
            end else if (ctrl_wr) begin
                if (dbg_di[0] && state == ST_HALTED) begin
                    state     <= ST_RUNNING;
                    ttlc_halt <= 1'b0;
                    skip      <= 1'b1;
                end else if (!dbg_di[0] && state == ST_RUNNING) begin
                    state      <= ST_HALTED;
                    ttlc_halt  <= 1'b1;
                    halt_event <= 1'b1;
                    reason     <= RSN_HOST;
                end
            end else if (ext_halt_req) begin
                if (state != ST_HALTED) begin
                    state      <= ST_HALTED;
                    ttlc_halt  <= 1'b1;
                    halt_event <= 1'b1;
                    reason     <= RSN_HOST;
                end
            end else if (brk_hit) begin
                state      <= ST_HALTED;
                ttlc_halt  <= 1'b1;
                halt_event <= 1'b1;
                reason     <= RSN_BRK;
            end else if (step_done) begin
                state      <= ST_HALTED;
                ttlc_halt  <= 1'b1;
                halt_event <= 1'b1;
                reason     <= RSN_STEP;
            end
        end
    end

    // Breakpoint configuration, sticky hits and the retired-instruction counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            brk_en   <= '0;
            hit      <= '0;
            brk_addr <= '0;
            icount   <= '0;
        end else begin
            if (wr && ofs == OFS_BRK_EN) brk_en <= dbg_di[NUM_BRK-1:0];
            for (int unsigned i = 0; i < NUM_BRK; i++) begin
                if (wr && ofs == 4'(32'(OFS_BRK_ADDR) + i)) brk_addr[i] <= dbg_di[PC_WIDTH-1:0];
            end
            hit <= (hit & ~hit_clr) | (brk_live ? match : '0);
            if (wr && ofs == OFS_ICOUNT) begin
                icount <= '0;
            end else if (ttlc_i_ready && state != ST_HALTED) begin
                icount <= icount + DBG_DW'(1);
            end
        end
    end

    always_comb begin
        dbg_do = '0;
        if (sel && dbg_rd) begin
            case (ofs)
                OFS_CTRL:   dbg_do = {8'h00, reason, ttlc_data_out, ttlc_data_in,
                                      ttlc_result_reg, skip, state};
                OFS_PC:     dbg_do = DBG_DW'(ttlc_pc);
                OFS_STEP_N: dbg_do = count;
                OFS_BRK_EN: dbg_do = DBG_DW'(brk_en);
                OFS_HIT:    dbg_do = DBG_DW'(hit);
                OFS_ICOUNT: dbg_do = icount;
                default: begin
                    for (int unsigned i = 0; i < NUM_BRK; i++) begin
                        if (ofs == 4'(32'(OFS_BRK_ADDR) + i)) dbg_do = DBG_DW'(brk_addr[i]);
                    end
                end
            endcase
        end
    end

endmodule
